// File: rtl/divider_pkg.sv
// Shared widths and state encoding for the 32/16 restoring divider.
package divider_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int REM_W      = 17;
    localparam int ITER_COUNT = 16;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, and keep the difference when it does not go negative.
module div_step
    import divider_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     rem_next,
    output logic                 q_bit
);

    logic [REM_W-1:0] shifted;
    logic             carry;

    // Shift/compare/subtract; the bit shifted out of the top counts as weight 2^17,
    // so a set carry always means the divisor fits and the modular subtract is exact.
    always_comb begin
        shifted  = {rem_in[REM_W-2:0], dividend_bit};
        carry    = rem_in[REM_W-1];
        q_bit    = carry | (shifted >= {1'b0, divisor});
        rem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/sixteen_bit_divider.sv
// 32-bit by 16-bit unsigned sequential divider: 16 restoring steps per
// division, with early exit to DONE for divide-by-zero and quotient overflow.
module sixteen_bit_divider
    import divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic [DIVISOR_W-1:0]  Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [REM_W-1:0]     rem;
    logic [DIVISOR_W-1:0] dvd_lo;
    logic [DIVISOR_W-1:0] divisor;
    logic [DIVISOR_W-1:0] quo;
    logic [REM_W-1:0]     rem_next;
    logic                 q_bit;

    div_step u_step (
        .rem_in       (rem),
        .dividend_bit (dvd_lo[DIVISOR_W-1]),
        .divisor      (divisor),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // Status decoded straight from the state register.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // FSM, iteration counter, operand latches and result registers.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            dvd_lo      <= '0;
            divisor     <= '0;
            quo         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            Q           <= '1;
                            R           <= A[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            state       <= DONE;
                        end else if (A[DIVIDEND_W-1:DIVISOR_W] >= B) begin
                            Q           <= '1;
                            R           <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            // The high dividend half is already < B, so it is the
                            // starting partial remainder; the low half is shifted in.
                            rem         <= {1'b0, A[DIVIDEND_W-1:DIVISOR_W]};
                            dvd_lo      <= A[DIVISOR_W-1:0];
                            divisor     <= B;
                            quo         <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem    <= rem_next;
                    dvd_lo <= {dvd_lo[DIVISOR_W-2:0], 1'b0};
                    quo    <= {quo[DIVISOR_W-2:0], q_bit};
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        Q     <= {quo[DIVISOR_W-2:0], q_bit};
                        R     <= rem_next[DIVISOR_W-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
